// File: rtl/clkdiv_pkg.sv
// Shared definitions for the programmable clock divider controller.
package clkdiv_pkg;

    // Controller state: idle, counting, counting with a divisor waiting to apply.
    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    // Smallest divisor that yields a real high and low phase.
    localparam int MIN_DIV = 2;

    // Length of the high phase; odd divisors get the extra cycle high.
    function automatic logic [31:0] hi_len(input logic [31:0] n);
        return n - (n >> 1);
    endfunction

endpackage

// File: rtl/clkdiv_counter.sv
// Period counter: runs 0..act_div-1 and wraps, held at 0 while clr is high.
module clkdiv_counter
    import clkdiv_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] act_div,
    output logic [W-1:0] cnt,
    output logic         last,
    output logic         phase_hi_next
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_nxt;

    // Next count and the high-phase decision for the cycle that follows.
    // act_div only changes while cnt is 0 or wrapping, so cnt never passes act_div-1.
    always_comb begin
        last          = (cnt == act_div - ONE);
        cnt_nxt       = (clr || last) ? '0 : cnt + ONE;
        phase_hi_next = (32'(cnt_nxt) < hi_len(32'(act_div)));
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_nxt;
    end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Divide-by-N controller: FSM, divisor registers, cfg handshake and output flops.
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int W       = 8,
    parameter int DEF_DIV = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_div,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic         div_out,
    output logic         div_outbar,
    output logic         tick,
    output logic         busy
);

    localparam logic [W-1:0] ONE   = W'(1);
    localparam logic [W-1:0] MIN_N = W'(MIN_DIV);

    state_t       state, state_nxt;
    logic [W-1:0] act_div, act_nxt;
    logic [W-1:0] pend_div, pend_nxt;
    logic [W-1:0] cnt;
    logic         last, phase_hi_next;
    logic         xfer, cfg_ok, clr, run_nxt, tick_nxt;

    assign cfg_ready = (state != ST_PEND);
    assign busy      = (state != ST_OFF);
    assign xfer      = cfg_valid & cfg_ready;
    assign cfg_ok    = (cfg_div >= MIN_N);
    assign clr       = (state == ST_OFF);

    clkdiv_counter #(.W(W)) u_cnt (
        .clk           (clk),
        .rst           (rst),
        .clr           (clr),
        .act_div       (act_div),
        .cnt           (cnt),
        .last          (last),
        .phase_hi_next (phase_hi_next)
    );

    // Next state and divisor updates; divisor changes land only on period boundaries.
    always_comb begin
        state_nxt = state;
        act_nxt   = act_div;
        pend_nxt  = pend_div;
        case (state)
            ST_OFF: begin
                if (xfer && cfg_ok) act_nxt = cfg_div;
                if (en)             state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (xfer && cfg_ok) begin
                    pend_nxt  = cfg_div;
                    state_nxt = ST_PEND;
                end else if (last && !en) begin
                    state_nxt = ST_OFF;
                end
            end
            ST_PEND: begin
                if (last) begin
                    act_nxt   = pend_div;
                    state_nxt = en ? ST_RUN : ST_OFF;
                end
            end
            default: state_nxt = ST_OFF;
        endcase
    end

    // Tick is registered, so predict "next cycle is the last": the counter is not
    // cleared or wrapping and cnt+1 hits act_div-1.
    always_comb begin
        run_nxt  = (state_nxt != ST_OFF);
        tick_nxt = run_nxt && !clr && !last && (cnt + ONE == act_div - ONE);
    end

    // State and divisor registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_OFF;
            act_div  <= W'(DEF_DIV);
            pend_div <= W'(DEF_DIV);
        end else begin
            state    <= state_nxt;
            act_div  <= act_nxt;
            pend_div <= pend_nxt;
        end
    end

    // Output flops, all updated on the same edge so the pair never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_out    <= 1'b0;
            div_outbar <= 1'b1;
            tick       <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            div_out    <= run_nxt & phase_hi_next;
            div_outbar <= ~(run_nxt & phase_hi_next);
            tick       <= tick_nxt;
            cfg_err    <= xfer & ~cfg_ok;
        end
    end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Self-checking bench for clkdiv_ctrl against a cycle-level period model.
module tb_clkdiv_ctrl;

    localparam int W   = 8;
    localparam int DEF = 2;

    logic         clk = 1'b0;
    logic         rst, en, cfg_valid;
    logic [W-1:0] cfg_div;
    logic         cfg_ready, cfg_err, div_out, div_outbar, tick, busy;
    logic [5:0]   obs;

    int checks = 0;
    int passed = 0;

    // Reference model: running flag, pending flag, position within period, divisors.
    bit m_on, m_pend, m_err;
    int m_pos, m_n, m_pn;

    assign obs = {div_out, div_outbar, tick, busy, cfg_ready, cfg_err};

    always #5 clk = ~clk;

    clkdiv_ctrl #(.W(W), .DEF_DIV(DEF)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .div_out    (div_out),
        .div_outbar (div_outbar),
        .tick       (tick),
        .busy       (busy)
    );

    function automatic logic [5:0] exp_vec();
        logic d;
        d = m_on && (m_pos < m_n - m_n / 2);
        return {d, !d, m_on && (m_pos == m_n - 1), m_on, !m_pend, m_err};
    endfunction

    task automatic model_reset();
        m_on = 0; m_pend = 0; m_err = 0; m_pos = 0; m_n = DEF; m_pn = DEF;
    endtask

    // Advance one clock; the model applies the rules to the inputs seen at the edge.
    task automatic cycle();
        bit xfer, ok, at_end;
        xfer = cfg_valid && !m_pend;
        ok   = (cfg_div >= 2);
        @(posedge clk);
        m_err = xfer && !ok;
        if (!m_on) begin
            if (xfer && ok) m_n = int'(cfg_div);
            m_pos = 0;
            m_on  = en;
        end else begin
            at_end = (m_pos == m_n - 1);
            m_pos  = at_end ? 0 : m_pos + 1;
            if (m_pend) begin
                if (at_end) begin
                    m_n = m_pn; m_pend = 0; m_on = en;
                end
            end else if (xfer && ok) begin
                m_pn = int'(cfg_div); m_pend = 1;
            end else if (at_end && !en) begin
                m_on = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 0; cfg_valid = 0; cfg_div = '0;
        model_reset();
        #2;
        checks++;
        if (obs !== 6'b010010) $display("FAIL reset_async got %b want %b", obs, 6'b010010);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (obs !== 6'b010010) $display("FAIL reset_hold got %b want %b", obs, 6'b010010);
        else passed++;
        rst = 0;
        cycle();
        checks++;
        if (obs !== exp_vec()) $display("FAIL reset_idle got %b want %b", obs, exp_vec());
        else passed++;
    endtask

    task automatic test_default();
        logic [9:0] pd, pt;
        pd = '0; pt = '0;
        en = 1;
        repeat (10) begin
            cycle();
            checks++;
            if (obs !== exp_vec()) $display("FAIL default_cyc got %b want %b", obs, exp_vec());
            else passed++;
            pd = {pd[8:0], div_out};
            pt = {pt[8:0], tick};
        end
        checks++;
        if (pd !== 10'b1010101010) $display("FAIL default_div got %b want %b", pd, 10'b1010101010);
        else passed++;
        checks++;
        if (pt !== 10'b0101010101) $display("FAIL default_tick got %b want %b", pt, 10'b0101010101);
        else passed++;
    endtask

    task automatic test_n5();
        logic [9:0] pd, pt;
        pd = '0; pt = '0;
        en = 0;
        for (int k = 0; k < 20 && m_on; k++) cycle();
        checks++;
        if ({busy, cfg_ready} !== 2'b01) $display("FAIL n5_off got busy/ready %b want 01", {busy, cfg_ready});
        else passed++;
        cfg_valid = 1; cfg_div = 8'd5;
        cycle();
        cfg_valid = 0; en = 1;
        repeat (10) begin
            cycle();
            checks++;
            if (obs !== exp_vec()) $display("FAIL n5_cyc got %b want %b", obs, exp_vec());
            else passed++;
            pd = {pd[8:0], div_out};
            pt = {pt[8:0], tick};
        end
        checks++;
        if (pd !== 10'b1110011100) $display("FAIL n5_div got %b want %b", pd, 10'b1110011100);
        else passed++;
        checks++;
        if (pt !== 10'b0000100001) $display("FAIL n5_tick got %b want %b", pt, 10'b0000100001);
        else passed++;
    endtask

    task automatic test_pend();
        logic [10:0] pd, pr;
        pd = '0; pr = '0;
        for (int k = 0; k < 20 && m_pos != 1; k++) cycle();
        checks++;
        if (obs !== exp_vec() || m_pos != 1) $display("FAIL pend_align got %b want %b pos %0d", obs, exp_vec(), m_pos);
        else passed++;
        cfg_valid = 1; cfg_div = 8'd4;
        cycle();
        cfg_valid = 0;
        // Observed cycles start at cnt=2 of the old N=5 period.
        pd = {pd[9:0], div_out}; pr = {pr[9:0], cfg_ready};
        repeat (10) begin
            cycle();
            checks++;
            if (obs !== exp_vec()) $display("FAIL pend_cyc got %b want %b", obs, exp_vec());
            else passed++;
            pd = {pd[9:0], div_out}; pr = {pr[9:0], cfg_ready};
        end
        checks++;
        if (pd !== 11'b10011001100) $display("FAIL pend_div got %b want %b", pd, 11'b10011001100);
        else passed++;
        checks++;
        if (pr !== 11'b00011111111) $display("FAIL pend_ready got %b want %b", pr, 11'b00011111111);
        else passed++;
    endtask

    task automatic test_err();
        cfg_valid = 1; cfg_div = 8'd1;
        cycle();
        checks++;
        if ({cfg_err, cfg_ready} !== 2'b11) $display("FAIL err_n1 got err/ready %b want 11", {cfg_err, cfg_ready});
        else passed++;
        cfg_div = 8'd0;
        cycle();
        checks++;
        if ({cfg_err, cfg_ready} !== 2'b11) $display("FAIL err_n0 got err/ready %b want 11", {cfg_err, cfg_ready});
        else passed++;
        cfg_valid = 0;
        cycle();
        checks++;
        if (cfg_err !== 1'b0) $display("FAIL err_clear got %b want 0", cfg_err);
        else passed++;
        repeat (8) begin
            cycle();
            checks++;
            if (obs !== exp_vec()) $display("FAIL err_cyc got %b want %b", obs, exp_vec());
            else passed++;
        end
    endtask

    task automatic test_drop_en();
        int n;
        bit saw_tick;
        n = 0; saw_tick = 0;
        cfg_valid = 1; cfg_div = 8'd6;
        cycle();
        cfg_valid = 0;
        for (int k = 0; k < 40 && (m_pend || m_n != 6 || m_pos != 2); k++) cycle();
        checks++;
        if (obs !== exp_vec() || m_pos != 2) $display("FAIL drop_align got %b want %b pos %0d", obs, exp_vec(), m_pos);
        else passed++;
        en = 0;
        for (int k = 0; k < 20 && busy !== 1'b0; k++) begin
            cycle();
            n++;
            if (tick === 1'b1) saw_tick = 1;
            checks++;
            if (obs !== exp_vec()) $display("FAIL drop_cyc got %b want %b", obs, exp_vec());
            else passed++;
        end
        checks++;
        if (n != 4 || !saw_tick || div_out !== 1'b0) $display("FAIL drop_len got %0d cycles tick %0d div %b want 4 1 0", n, saw_tick, div_out);
        else passed++;
    endtask

    task automatic test_rst_mid();
        logic [5:0] pd;
        pd = '0;
        cfg_valid = 1; cfg_div = 8'd7;
        cycle();
        cfg_valid = 0; en = 1;
        for (int k = 0; k < 20 && m_pos != 1; k++) cycle();
        cfg_valid = 1; cfg_div = 8'd3;
        cycle();
        cfg_valid = 0;
        cycle();
        checks++;
        if (obs !== exp_vec() || m_pos != 3) $display("FAIL rstmid_pre got %b want %b pos %0d", obs, exp_vec(), m_pos);
        else passed++;
        #2 rst = 1;
        #1;
        checks++;
        if (obs !== 6'b010010) $display("FAIL rstmid_async got %b want %b", obs, 6'b010010);
        else passed++;
        model_reset();
        @(posedge clk); #1;
        rst = 0;
        repeat (6) begin
            cycle();
            checks++;
            if (obs !== exp_vec()) $display("FAIL rstmid_cyc got %b want %b", obs, exp_vec());
            else passed++;
            pd = {pd[4:0], div_out};
        end
        checks++;
        if (pd !== 6'b101010) $display("FAIL rstmid_def got %b want %b", pd, 6'b101010);
        else passed++;
    endtask

    task automatic test_max();
        int ticks, highs;
        ticks = 0; highs = 0;
        en = 0;
        for (int k = 0; k < 20 && m_on; k++) cycle();
        cfg_valid = 1; cfg_div = 8'd255;
        cycle();
        cfg_valid = 0; en = 1;
        repeat (510) begin
            cycle();
            checks++;
            if (obs !== exp_vec()) $display("FAIL max_cyc got %b want %b", obs, exp_vec());
            else passed++;
            if (tick === 1'b1) ticks++;
            if (div_out === 1'b1) highs++;
        end
        checks++;
        if (ticks != 2 || highs != 256) $display("FAIL max_shape got ticks %0d highs %0d want 2 256", ticks, highs);
        else passed++;
    endtask

    task automatic test_random();
        repeat (800) begin
            if ($urandom_range(0, 15) == 0) en = !en;
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_div   = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1)) : W'($urandom_range(2, 9));
            cycle();
            checks++;
            if (obs !== exp_vec()) $display("FAIL rand_cyc got %b want %b", obs, exp_vec());
            else passed++;
        end
        cfg_valid = 0;
    endtask

    initial begin
        test_reset();
        test_default();
        test_n5();
        test_pend();
        test_err();
        test_drop_en();
        test_rst_mid();
        test_max();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
